addr_region_router: RTL and testbench
=====================================

# addr_region_router

Registered, parametrised address decoder for the memory subsystem. It sits between the CPU load/store/fetch port and the flash, BRAM, SRAM and peripheral targets. It accepts one request per cycle through a valid/ready handshake and emits a one-hot region select one cycle later. Unmapped accesses return an error response instead of a select, and the block records them in sticky fault-capture registers that software can read and clear.

## Interface
Parameters:
- ADDR_W, 32, address width.
- NUM_REGIONS, 4, number of decoded targets.
- REGION_BASE, {0x0003_0000, 0x0002_0000, 0x0001_0000, 0x0000_0000}, packed NUM_REGIONS×ADDR_W bases; region i occupies slice i.
- REGION_MASK, all 0xFFFF_0000, packed NUM_REGIONS×ADDR_W compare masks.
- CNT_W, 8, width of the fault counter.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, request accepted when high with req_valid.
- req_addr, in, ADDR_W, request address.
- req_write, in, 1, write flag, carried through.
- rsp_valid, out, 1, decoded response held.
- rsp_ready, in, 1, downstream accepts the response.
- rsp_sel, out, NUM_REGIONS, one-hot region select; all zero on error.
- rsp_err, out, 1, unmapped address.
- rsp_addr, out, ADDR_W, registered copy of the address.
- rsp_write, out, 1, registered copy of req_write.
- err_pending, out, 1, sticky fault flag.
- err_addr, out, ADDR_W, address of the first fault since the last clear.
- err_overflow, out, 1, set when a further fault arrives while err_pending is high.
- err_count, out, CNT_W, saturating fault count.
- err_clr, in, 1, synchronous clear of all err_* state.

## Operation
- Match rule: region i hits when (req_addr & REGION_MASK[i]) == (REGION_BASE[i] & REGION_MASK[i]).
- If several regions hit, the lowest index wins. rsp_sel is always one-hot or zero.
- No hit gives rsp_err=1 and rsp_sel=0.
- The output stage is a single register. Handshake rule: req_ready = !rsp_valid || rsp_ready.
- Load: on req_valid && req_ready, load rsp_sel, rsp_err, rsp_addr and rsp_write, and set rsp_valid.
- Drain: on rsp_ready with no new accept, clear rsp_valid.
- While rsp_valid && !rsp_ready, every rsp_* output holds stable.
- An error response is a normal beat and needs rsp_ready to retire.
- Fault capture happens at accept time, when a miss is accepted:
  - If err_pending=0: set err_pending and latch err_addr.
  - Otherwise: set err_overflow; err_addr keeps the first fault.
  - err_count increments and saturates at 2^CNT_W-1.
- err_clr in the same cycle as an accepted miss: the clear is applied first, then the capture. Result: err_pending=1, err_addr=new address, err_overflow=0, err_count=1.

## Timing
- Latency from accept to rsp_valid is 1 cycle.
- Throughput is 1 request per cycle while rsp_ready is held high.
- Reset values: rsp_valid=0, rsp_sel=0, rsp_err=0, rsp_addr=0, rsp_write=0, err_pending=0, err_addr=0, err_overflow=0, err_count=0.
- req_ready is combinational, so it is 1 during reset.
- Reset asserted mid-transaction drops the held response with no retirement, and the fault state is lost.
- The decode path is purely combinational from req_addr into the output register. There is no path from rsp_ready to rsp_*.
- err_* outputs update on the clock edge after the accepting cycle.

## Structure
- Package addr_map_pkg holds:
  - the default base/mask constants (FLASH, BRAM, SRAM and PERIPH at 0x0000/0x0001/0x0002/0x0003 in the upper half-word);
  - region index localparams REG_FLASH=0, REG_BRAM=1, REG_SRAM=2, REG_PERIPH=3.
- Sub-module addr_region_match: combinational mask compare plus lowest-index priority encoder. It outputs the one-hot select and a miss flag. The top level holds the output register, handshake and fault capture.

## Test plan
- Back-to-back accesses with rsp_ready=1 to 0x0000_0100, 0x0001_0004, 0x0002_0008 and 0x0003_000C produce rsp_sel 0001, 0010, 0100, 1000 on consecutive cycles, each with rsp_err=0.
- Access to 0x0004_0000 produces rsp_sel=0 and rsp_err=1. The next cycle shows err_pending=1, err_addr=0x0004_0000, err_count=1.
- A second miss to 0xFFFF_0000 before any clear gives err_overflow=1, err_count=2, and err_addr still 0x0004_0000.
- With rsp_ready held low for 3 cycles: req_ready=0 and all rsp_* outputs stay stable. Releasing rsp_ready retires the beat, and a waiting request is accepted in that same cycle.
- err_clr in the same cycle as an accepted miss at 0x0005_0000 gives err_count=1, err_overflow=0, err_addr=0x0005_0000.
- Two distinct faults:
  - With err_count preloaded by 255 faults (CNT_W=8), a further miss leaves err_count=255.
  - Asserting rst_n low while rsp_valid=1 immediately returns every output to its reset value.

Source files
------------

// File: rtl/addr_map_pkg.sv
// Default memory map for the CPU address decoder: region bases, compare masks
// and region index constants shared by the router and its users.
package addr_map_pkg;

    localparam int unsigned MAP_ADDR_W = 32;
    localparam int unsigned MAP_NUM_REGIONS = 4;

    localparam int unsigned REG_FLASH  = 0;
    localparam int unsigned REG_BRAM   = 1;
    localparam int unsigned REG_SRAM   = 2;
    localparam int unsigned REG_PERIPH = 3;

    localparam logic [MAP_ADDR_W-1:0] FLASH_BASE  = 32'h0000_0000;
    localparam logic [MAP_ADDR_W-1:0] BRAM_BASE   = 32'h0001_0000;
    localparam logic [MAP_ADDR_W-1:0] SRAM_BASE   = 32'h0002_0000;
    localparam logic [MAP_ADDR_W-1:0] PERIPH_BASE = 32'h0003_0000;

    // Each target decodes on the upper half-word only.
    localparam logic [MAP_ADDR_W-1:0] REGION_MASK_64K = 32'hFFFF_0000;

    // Region i lives in slice i, so the highest index sits leftmost.
    localparam logic [MAP_NUM_REGIONS*MAP_ADDR_W-1:0] DEFAULT_REGION_BASE =
        {PERIPH_BASE, SRAM_BASE, BRAM_BASE, FLASH_BASE};

    localparam logic [MAP_NUM_REGIONS*MAP_ADDR_W-1:0] DEFAULT_REGION_MASK =
        {REGION_MASK_64K, REGION_MASK_64K, REGION_MASK_64K, REGION_MASK_64K};

endpackage

// File: rtl/addr_region_match.sv
// Combinational region decode: masked compare against every region base and a
// lowest-index priority pick, producing a one-hot select and a miss flag.
module addr_region_match #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = '0
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic [NUM_REGIONS-1:0] sel,
    output logic                   miss
);

    logic [NUM_REGIONS-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            hit[i] = ((addr & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
                      (REGION_BASE[i*ADDR_W +: ADDR_W] & REGION_MASK[i*ADDR_W +: ADDR_W]));
        end
    end

    // Lowest index wins so overlapping maps still yield a one-hot select.
    always_comb begin
        logic found;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (hit[i] && !found) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
        miss = !found;
    end

endmodule

// File: rtl/addr_region_router.sv
// Registered address router: one-beat output register with valid/ready
// handshake, one-hot region select, and sticky capture of unmapped accesses.
module addr_region_router
    import addr_map_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEFAULT_REGION_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = DEFAULT_REGION_MASK,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic                   req_write,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [NUM_REGIONS-1:0] rsp_sel,
    output logic                   rsp_err,
    output logic [ADDR_W-1:0]      rsp_addr,
    output logic                   rsp_write,
    output logic                   err_pending,
    output logic [ADDR_W-1:0]      err_addr,
    output logic                   err_overflow,
    output logic [CNT_W-1:0]       err_count,
    input  logic                   err_clr
);

    logic [NUM_REGIONS-1:0] dec_sel;
    logic                   dec_miss;
    logic                   accept;

    logic                   rsp_valid_q, rsp_valid_d;
    logic [NUM_REGIONS-1:0] rsp_sel_q, rsp_sel_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0]      rsp_addr_q, rsp_addr_d;
    logic                   rsp_write_q, rsp_write_d;

    logic                   err_pending_q, err_pending_d;
    logic [ADDR_W-1:0]      err_addr_q, err_addr_d;
    logic                   err_overflow_q, err_overflow_d;
    logic [CNT_W-1:0]       err_count_q, err_count_d;

    addr_region_match #(
        .ADDR_W      (ADDR_W),
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_match (
        .addr (req_addr),
        .sel  (dec_sel),
        .miss (dec_miss)
    );

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_sel_d   = rsp_sel_q;
        rsp_err_d   = rsp_err_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_write_d = rsp_write_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_sel_d   = dec_sel;
            rsp_err_d   = dec_miss;
            rsp_addr_d  = req_addr;
            rsp_write_d = req_write;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Clear is applied before capture so a same-cycle miss becomes the first fault.
    always_comb begin
        err_pending_d  = err_pending_q;
        err_addr_d     = err_addr_q;
        err_overflow_d = err_overflow_q;
        err_count_d    = err_count_q;
        if (err_clr) begin
            err_pending_d  = 1'b0;
            err_addr_d     = '0;
            err_overflow_d = 1'b0;
            err_count_d    = '0;
        end
        if (accept && dec_miss) begin
            if (!err_pending_d) begin
                err_pending_d = 1'b1;
                err_addr_d    = req_addr;
            end else begin
                err_overflow_d = 1'b1;
            end
            if (err_count_d != {CNT_W{1'b1}}) begin
                err_count_d = err_count_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q    <= 1'b0;
            rsp_sel_q      <= '0;
            rsp_err_q      <= 1'b0;
            rsp_addr_q     <= '0;
            rsp_write_q    <= 1'b0;
            err_pending_q  <= 1'b0;
            err_addr_q     <= '0;
            err_overflow_q <= 1'b0;
            err_count_q    <= '0;
        end else begin
            rsp_valid_q    <= rsp_valid_d;
            rsp_sel_q      <= rsp_sel_d;
            rsp_err_q      <= rsp_err_d;
            rsp_addr_q     <= rsp_addr_d;
            rsp_write_q    <= rsp_write_d;
            err_pending_q  <= err_pending_d;
            err_addr_q     <= err_addr_d;
            err_overflow_q <= err_overflow_d;
            err_count_q    <= err_count_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_sel      = rsp_sel_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_addr     = rsp_addr_q;
    assign rsp_write    = rsp_write_q;
    assign err_pending  = err_pending_q;
    assign err_addr     = err_addr_q;
    assign err_overflow = err_overflow_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_addr_region_router.sv
// Scoreboard bench for addr_region_router: stimulus pushes expected beats,
// a monitor pops and compares each beat as it retires.
module tb_addr_region_router;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_sel;
    logic        rsp_err;
    logic [31:0] rsp_addr;
    logic        rsp_write;
    logic        err_pending;
    logic [31:0] err_addr;
    logic        err_overflow;
    logic [7:0]  err_count;
    logic        err_clr;

    typedef struct packed {
        logic [3:0]  sel;
        logic        err;
        logic [31:0] addr;
        logic        write;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    passes = 0;
    bit    track = 1'b1;

    addr_region_router dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_write    (req_write),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_sel      (rsp_sel),
        .rsp_err      (rsp_err),
        .rsp_addr     (rsp_addr),
        .rsp_write    (rsp_write),
        .err_pending  (err_pending),
        .err_addr     (err_addr),
        .err_overflow (err_overflow),
        .err_count    (err_count),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endfunction

    // Monitor: a beat retires on the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(rsp_addr), 64'hDEAD);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("rsp_sel", 64'(rsp_sel), 64'(e.sel));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
                check("rsp_addr", 64'(rsp_addr), 64'(e.addr));
                check("rsp_write", 64'(rsp_write), 64'(e.write));
            end
        end
    end

    task automatic send(input logic [31:0] addr, input logic wr,
                        input logic [3:0] esel, input logic eerr);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = wr;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            check("accept_timeout", 64'(addr), 64'hFFFF);
        end else begin
            if (track) exp_q.push_back('{sel: esel, err: eerr, addr: addr, write: wr});
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        rsp_ready = 1'b1; err_clr = 1'b0;
        #12;
        check("rst_rsp_valid", 64'(rsp_valid), 0);
        check("rst_rsp_sel", 64'(rsp_sel), 0);
        check("rst_err_count", 64'(err_count), 0);
        check("rst_err_pending", 64'(err_pending), 0);
        check("rst_req_ready", 64'(req_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back hits to every region.
        send(32'h0000_0100, 1'b0, 4'b0001, 1'b0);
        send(32'h0001_0004, 1'b1, 4'b0010, 1'b0);
        send(32'h0002_0008, 1'b0, 4'b0100, 1'b0);
        send(32'h0003_000C, 1'b1, 4'b1000, 1'b0);
        check("no_err_after_hits", 64'(err_pending), 0);

        send(32'h0004_0000, 1'b0, 4'b0000, 1'b1);
        check("miss1_pending", 64'(err_pending), 1);
        check("miss1_addr", 64'(err_addr), 64'h0004_0000);
        check("miss1_count", 64'(err_count), 1);
        check("miss1_overflow", 64'(err_overflow), 0);

        send(32'hFFFF_0000, 1'b1, 4'b0000, 1'b1);
        check("miss2_overflow", 64'(err_overflow), 1);
        check("miss2_count", 64'(err_count), 2);
        check("miss2_addr", 64'(err_addr), 64'h0004_0000);

        // Backpressure: hold a beat for 3 cycles with a request waiting.
        repeat (2) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        send(32'h0002_0010, 1'b1, 4'b0100, 1'b0);
        req_valid = 1'b1; req_addr = 32'h0001_0020; req_write = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_req_ready", 64'(req_ready), 0);
            check("stall_rsp_valid", 64'(rsp_valid), 1);
            check("stall_rsp_sel", 64'(rsp_sel), 64'b0100);
            check("stall_rsp_addr", 64'(rsp_addr), 64'h0002_0010);
            check("stall_rsp_write", 64'(rsp_write), 1);
            check("stall_rsp_err", 64'(rsp_err), 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("release_req_ready", 64'(req_ready), 1);
        exp_q.push_back('{sel: 4'b0010, err: 1'b0, addr: 32'h0001_0020, write: 1'b0});
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("release_new_beat", 64'(rsp_addr), 64'h0001_0020);

        // Clear together with a new miss.
        err_clr = 1'b1;
        send(32'h0005_0000, 1'b0, 4'b0000, 1'b1);
        err_clr = 1'b0;
        check("clr_miss_count", 64'(err_count), 1);
        check("clr_miss_overflow", 64'(err_overflow), 0);
        check("clr_miss_addr", 64'(err_addr), 64'h0005_0000);
        check("clr_miss_pending", 64'(err_pending), 1);

        // Saturation: 255 faults then one more.
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("clr_count", 64'(err_count), 0);
        check("clr_pending", 64'(err_pending), 0);
        for (int k = 0; k < 255; k++) begin
            send(32'h1000_0000 + 32'(k), 1'b0, 4'b0000, 1'b1);
        end
        check("sat_count_255", 64'(err_count), 255);
        send(32'h2000_0000, 1'b0, 4'b0000, 1'b1);
        check("sat_count_hold", 64'(err_count), 255);
        check("sat_overflow", 64'(err_overflow), 1);
        check("sat_addr_first", 64'(err_addr), 64'h1000_0000);

        // Reset while a beat is held: the beat is dropped, not retired.
        repeat (2) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        track = 1'b0;
        send(32'h0003_0000, 1'b1, 4'b1000, 1'b0);
        check("pre_rst_valid", 64'(rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 64'(rsp_valid), 0);
        check("mid_rst_rsp_sel", 64'(rsp_sel), 0);
        check("mid_rst_rsp_addr", 64'(rsp_addr), 0);
        check("mid_rst_rsp_write", 64'(rsp_write), 0);
        check("mid_rst_err_pending", 64'(err_pending), 0);
        check("mid_rst_err_addr", 64'(err_addr), 0);
        check("mid_rst_err_overflow", 64'(err_overflow), 0);
        check("mid_rst_err_count", 64'(err_count), 0);
        check("mid_rst_req_ready", 64'(req_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
